// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types for the hazard controller: scoreboard slot layouts,
// forwarding-source encoding and the write-hazard predicate.
package riscv_pipe_pkg;

    localparam int unsigned RF_AW = 5;

    typedef struct packed {
        logic             valid;
        logic [RF_AW-1:0] rd;
        logic             wb_en;
        logic             from_mem;
    } hz_slot_t;

    typedef struct packed {
        hz_slot_t         hz;
        logic [RF_AW-1:0] rs1;
        logic [RF_AW-1:0] rs2;
        logic             use_rs1;
        logic             use_rs2;
    } ex_slot_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    // A slot only matters for hazards when it really writes a non-x0 register.
    function automatic logic is_hazard_src(input hz_slot_t s);
        return s.valid && s.wb_en && (s.rd != {RF_AW{1'b0}});
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Forwarding-source choice for one EX operand; MEM wins over WB because it
// holds the younger write, and a load in MEM is never a forwarding source.
module fwd_select
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned AW = 5
) (
    input  logic          use_rs,
    input  logic [AW-1:0] rs,
    input  logic          mem_hazard,
    input  logic [AW-1:0] mem_rd,
    input  logic          mem_from_mem,
    input  logic          wb_hazard,
    input  logic [AW-1:0] wb_rd,
    output logic [1:0]    sel
);

    fwd_sel_t sel_s;

    // Priority chain: unused/x0 operand, then MEM ALU result, then WB data.
    always_comb begin
        sel_s = FWD_RF;
        if (!use_rs || (rs == {AW{1'b0}})) begin
            sel_s = FWD_RF;
        end else if (mem_hazard && (mem_rd == rs) && !mem_from_mem) begin
            sel_s = FWD_MEM;
        end else if (wb_hazard && (wb_rd == rs)) begin
            sel_s = FWD_WB;
        end else begin
            sel_s = FWD_RF;
        end
    end

    assign sel = sel_s;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: tracks in-flight writes in EX/MEM/WB and drives
// stall, bubble, flush, freeze and operand forwarding for the 5-stage core.
module hazard_controller
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned XREG_AW = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [XREG_AW-1:0] id_rs1_addr,
    input  logic [XREG_AW-1:0] id_rs2_addr,
    input  logic [XREG_AW-1:0] id_rd_addr,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic               id_writeback_en,
    input  logic               id_writeback_from_mem,
    input  logic               ex_redirect,
    input  logic               mem_busy,
    output logic               stall_if,
    output logic               stall_id,
    output logic               bubble_ex,
    output logic               flush_if_id,
    output logic               freeze,
    output logic [1:0]         fwd_rs1_sel,
    output logic [1:0]         fwd_rs2_sel
);

    ex_slot_t   ex_slot_r;
    hz_slot_t   mem_slot_r;
    hz_slot_t   wb_slot_r;

    ex_slot_t   id_slot_s;
    logic       lu_s;
    logic       redirect_s;
    logic [1:0] sel_rs1_s;
    logic [1:0] sel_rs2_s;

    // Pack the decoder fields into the EX slot layout (addresses sized to the slot).
    always_comb begin
        id_slot_s             = '0;
        id_slot_s.hz.valid    = id_valid;
        id_slot_s.hz.rd       = RF_AW'(id_rd_addr);
        id_slot_s.hz.wb_en    = id_writeback_en;
        id_slot_s.hz.from_mem = id_writeback_from_mem;
        id_slot_s.rs1         = RF_AW'(id_rs1_addr);
        id_slot_s.rs2         = RF_AW'(id_rs2_addr);
        id_slot_s.use_rs1     = id_use_rs1;
        id_slot_s.use_rs2     = id_use_rs2;
    end

    // Load-use detection against the load currently in EX, and redirect qualification.
    always_comb begin
        lu_s = 1'b0;
        if (id_valid && is_hazard_src(ex_slot_r.hz) && ex_slot_r.hz.from_mem) begin
            lu_s = (id_use_rs1 && (id_slot_s.rs1 == ex_slot_r.hz.rd)) ||
                   (id_use_rs2 && (id_slot_s.rs2 == ex_slot_r.hz.rd));
        end else begin
            lu_s = 1'b0;
        end
        redirect_s = ex_redirect && ex_slot_r.hz.valid;
    end

    // Control outputs in priority order: reset, memory freeze, redirect, load-use.
    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        bubble_ex   = 1'b0;
        flush_if_id = 1'b0;
        freeze      = 1'b0;
        if (rst) begin
            flush_if_id = 1'b1;
            bubble_ex   = 1'b1;
        end else if (mem_busy) begin
            freeze   = 1'b1;
            stall_if = 1'b1;
            stall_id = 1'b1;
        end else if (redirect_s) begin
            flush_if_id = 1'b1;
            bubble_ex   = 1'b1;
        end else if (lu_s) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
        end else begin
            stall_if = 1'b0;
        end
    end

    // Scoreboard advance; a freeze holds every slot so forwarding stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_slot_r  <= '0;
            mem_slot_r <= '0;
            wb_slot_r  <= '0;
        end else if (!mem_busy) begin
            wb_slot_r  <= mem_slot_r;
            mem_slot_r <= ex_slot_r.hz;
            ex_slot_r  <= (bubble_ex || !id_valid) ? ex_slot_t'('0) : id_slot_s;
        end else begin
            ex_slot_r <= ex_slot_r;
        end
    end

    fwd_select #(.AW(RF_AW)) u_fwd_rs1 (
        .use_rs       (ex_slot_r.use_rs1),
        .rs           (ex_slot_r.rs1),
        .mem_hazard   (is_hazard_src(mem_slot_r)),
        .mem_rd       (mem_slot_r.rd),
        .mem_from_mem (mem_slot_r.from_mem),
        .wb_hazard    (is_hazard_src(wb_slot_r)),
        .wb_rd        (wb_slot_r.rd),
        .sel          (sel_rs1_s)
    );

    fwd_select #(.AW(RF_AW)) u_fwd_rs2 (
        .use_rs       (ex_slot_r.use_rs2),
        .rs           (ex_slot_r.rs2),
        .mem_hazard   (is_hazard_src(mem_slot_r)),
        .mem_rd       (mem_slot_r.rd),
        .mem_from_mem (mem_slot_r.from_mem),
        .wb_hazard    (is_hazard_src(wb_slot_r)),
        .wb_rd        (wb_slot_r.rd),
        .sel          (sel_rs2_s)
    );

    // Forwarding is forced to the register file while reset is held.
    always_comb begin
        fwd_rs1_sel = 2'd0;
        fwd_rs2_sel = 2'd0;
        if (rst) begin
            fwd_rs1_sel = 2'd0;
            fwd_rs2_sel = 2'd0;
        end else begin
            fwd_rs1_sel = sel_rs1_s;
            fwd_rs2_sel = sel_rs2_s;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench: a driver issues instructions and pushes the expected
// controls/selects; a monitor pops and compares every cycle on the falling edge.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic       id_use_rs1, id_use_rs2, id_writeback_en, id_writeback_from_mem;
    logic       ex_redirect, mem_busy;
    logic       stall_if, stall_id, bubble_ex, flush_if_id, freeze;
    logic [1:0] fwd_rs1_sel, fwd_rs2_sel;

    always #5 clk = ~clk;

    hazard_controller #(.XREG_AW(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_writeback_en(id_writeback_en), .id_writeback_from_mem(id_writeback_from_mem),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
        .flush_if_id(flush_if_id), .freeze(freeze),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel)
    );

    typedef struct {
        logic valid;
        int   rd, rs1, rs2;
        logic u1, u2, wb, ld;
    } instr_t;

    // ctl packs {stall_if, stall_id, bubble_ex, flush_if_id, freeze}
    typedef struct {
        logic [4:0] ctl;
        logic [1:0] s1, s2;
        string      tag;
    } exp_t;

    exp_t   sb[$];
    instr_t pipe[$];   // in-flight instructions: [0]=EX, [1]=MEM, [2]=WB
    instr_t empty_i;
    int     tests = 0;
    int     fails = 0;

    function automatic instr_t mk(logic v, int rd, int rs1, int rs2,
                                  logic u1, logic u2, logic wb, logic ld);
        instr_t i;
        i.valid = v; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
        i.u1 = u1; i.u2 = u2; i.wb = wb; i.ld = ld;
        return i;
    endfunction

    function automatic logic writes(instr_t i);
        return i.valid && i.wb && (i.rd != 0);
    endfunction

    // Where an EX operand should come from, given the older instructions in flight.
    function automatic logic [1:0] source_of(logic used, int r);
        if (!used || r == 0) return 2'd0;
        if (writes(pipe[1]) && pipe[1].rd == r && !pipe[1].ld) return 2'd1;
        if (writes(pipe[2]) && pipe[2].rd == r) return 2'd2;
        return 2'd0;
    endfunction

    task automatic step(input instr_t id, input logic redir, input logic busy,
                        input logic reset, input string tag);
        exp_t e;
        logic lu;
        @(posedge clk);
        #1;
        rst = reset; id_valid = id.valid;
        id_rd_addr = 5'(id.rd); id_rs1_addr = 5'(id.rs1); id_rs2_addr = 5'(id.rs2);
        id_use_rs1 = id.u1; id_use_rs2 = id.u2;
        id_writeback_en = id.wb; id_writeback_from_mem = id.ld;
        ex_redirect = redir; mem_busy = busy;

        lu = id.valid && writes(pipe[0]) && pipe[0].ld &&
             ((id.u1 && id.rs1 == pipe[0].rd) || (id.u2 && id.rs2 == pipe[0].rd));
        e.tag = tag;
        if (reset)                        e.ctl = 5'b00110;
        else if (busy)                    e.ctl = 5'b11001;
        else if (redir && pipe[0].valid)  e.ctl = 5'b00110;
        else if (lu)                      e.ctl = 5'b11100;
        else                              e.ctl = 5'b00000;
        e.s1 = reset ? 2'd0 : source_of(pipe[0].u1, pipe[0].rs1);
        e.s2 = reset ? 2'd0 : source_of(pipe[0].u2, pipe[0].rs2);
        sb.push_back(e);

        if (reset) begin
            pipe = '{empty_i, empty_i, empty_i};
        end else if (!busy) begin
            void'(pipe.pop_back());
            pipe.push_front((e.ctl[2] || !id.valid) ? empty_i : id);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        logic [4:0] ctl;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            ctl = {stall_if, stall_id, bubble_ex, flush_if_id, freeze};
            tests += 3;
            if (ctl !== e.ctl) begin
                fails++;
                $display("FAIL ctl[%s]: got %b expected %b", e.tag, ctl, e.ctl);
            end
            if (fwd_rs1_sel !== e.s1) begin
                fails++;
                $display("FAIL rs1_sel[%s]: got %0d expected %0d", e.tag, fwd_rs1_sel, e.s1);
            end
            if (fwd_rs2_sel !== e.s2) begin
                fails++;
                $display("FAIL rs2_sel[%s]: got %0d expected %0d", e.tag, fwd_rs2_sel, e.s2);
            end
        end
    end

    initial begin
        instr_t nop, a5, ld5;
        empty_i = mk(0, 0, 0, 0, 0, 0, 0, 0);
        nop     = empty_i;
        pipe    = '{empty_i, empty_i, empty_i};
        rst = 1'b1; id_valid = 1'b0; id_rd_addr = '0; id_rs1_addr = '0; id_rs2_addr = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_writeback_en = 1'b0;
        id_writeback_from_mem = 1'b0; ex_redirect = 1'b0; mem_busy = 1'b0;

        a5  = mk(1, 5, 1, 2, 1, 1, 1, 0);
        ld5 = mk(1, 5, 1, 0, 1, 0, 1, 1);

        step(nop, 0, 0, 1, "reset");
        step(nop, 0, 0, 1, "reset");
        // back-to-back ALU dependency, then with one independent op between
        step(a5, 0, 0, 0, "alu_dep");
        step(mk(1, 6, 5, 7, 1, 1, 1, 0), 0, 0, 0, "alu_dep");
        step(nop, 0, 0, 0, "alu_dep");
        step(a5, 0, 0, 0, "alu_gap");
        step(mk(1, 8, 1, 2, 1, 1, 1, 0), 0, 0, 0, "alu_gap");
        step(mk(1, 6, 5, 7, 1, 1, 1, 0), 0, 0, 0, "alu_gap");
        step(nop, 0, 0, 0, "alu_gap");
        // load-use: the consumer is held in ID across the stall
        step(ld5, 0, 0, 0, "load_use");
        step(mk(1, 6, 5, 5, 1, 1, 1, 0), 0, 0, 0, "load_use");
        step(mk(1, 6, 5, 5, 1, 1, 1, 0), 0, 0, 0, "load_use");
        step(nop, 0, 0, 0, "load_use");
        step(nop, 0, 0, 0, "load_use");
        // x0 writer/reader and jal with an unused rs1 field
        step(mk(1, 0, 1, 2, 1, 1, 1, 0), 0, 0, 0, "x0");
        step(mk(1, 6, 0, 0, 1, 1, 1, 0), 0, 0, 0, "x0");
        step(a5, 0, 0, 0, "jal");
        step(mk(1, 1, 5, 0, 0, 0, 1, 0), 0, 0, 0, "jal");
        step(nop, 0, 0, 0, "jal");
        // redirect in the same cycle as a load-use
        step(ld5, 0, 0, 0, "redir_lu");
        step(mk(1, 6, 5, 5, 1, 1, 1, 0), 1, 0, 0, "redir_lu");
        step(mk(1, 7, 5, 5, 1, 1, 1, 0), 0, 0, 0, "redir_lu");
        step(nop, 0, 0, 0, "redir_lu");
        // freeze mid-chain with a redirect request that must be ignored
        step(a5, 0, 0, 0, "freeze");
        step(mk(1, 6, 5, 7, 1, 1, 1, 0), 0, 0, 0, "freeze");
        step(mk(1, 7, 6, 5, 1, 1, 1, 0), 1, 1, 0, "freeze");
        step(mk(1, 7, 6, 5, 1, 1, 1, 0), 1, 1, 0, "freeze");
        step(mk(1, 7, 6, 5, 1, 1, 1, 0), 1, 1, 0, "freeze");
        step(mk(1, 7, 6, 5, 1, 1, 1, 0), 0, 0, 0, "freeze");
        step(nop, 0, 0, 0, "freeze");
        // reset during a freeze
        step(a5, 0, 0, 0, "rst_freeze");
        step(mk(1, 6, 5, 7, 1, 1, 1, 0), 0, 1, 0, "rst_freeze");
        step(mk(1, 6, 5, 7, 1, 1, 1, 0), 0, 1, 1, "rst_freeze");
        step(mk(1, 6, 5, 7, 1, 1, 1, 0), 0, 0, 0, "rst_freeze");
        step(nop, 0, 0, 0, "rst_freeze");

        // random traffic over a small register set to provoke hazards
        for (int n = 0; n < 800; n++) begin
            instr_t r;
            r = mk(($urandom_range(0, 9) != 0), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            step(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 49) == 0), "random");
        end

        // bounded drain of the scoreboard
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
